// File: rtl/inst_fetch_sram_pkg.sv
// Shared CPU definitions used by the fetch front end.
package inst_fetch_sram_pkg;

    typedef enum logic [1:0] {
        F_REQ,
        F_WAIT,
        F_FULL
    } fetch_state_e;

    localparam logic [1:0]  SIZE_WORD        = 2'b10;
    localparam logic [31:0] RESET_PC_DEFAULT = 32'hBFC0_0000;

endpackage

// File: rtl/inst_fetch_sram.sv
// Fetch stage: owns the fetch PC, drives the sram-like instruction bus,
// and buffers one returned word until decode takes it.
module inst_fetch_sram
    import inst_fetch_sram_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stallF,
    input  logic        flushF,
    input  logic [31:0] newpc,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        inst_req,
    output logic        inst_wr,
    output logic [1:0]  inst_size,
    output logic [31:0] inst_addr,
    output logic [31:0] inst_wdata,
    input  logic        inst_addr_ok,
    input  logic        inst_data_ok,
    input  logic [31:0] inst_rdata,
    output logic [31:0] instrF,
    output logic [31:0] pcF,
    output logic        validF,
    output logic        adelF,
    output logic        i_stall
);

    fetch_state_e state_q, state_d;
    logic [31:0]  pc_q, pc_d;
    logic [31:0]  addr_q, addr_d;
    logic [31:0]  buf_q, buf_d;
    logic [31:0]  buf_pc_q, buf_pc_d;
    logic         buf_adel_q, buf_adel_d;
    logic         cancel_q, cancel_d;

    logic         misal;
    logic         consume;
    logic [31:0]  next_pc;

    assign misal   = |addr_q[1:0];
    assign consume = ~stallF & ~flushF;
    assign next_pc = redirect_valid ? redirect_pc : buf_pc_q + 32'd4;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= F_REQ;
            pc_q       <= RESET_PC;
            addr_q     <= RESET_PC;
            buf_q      <= 32'h0;
            buf_pc_q   <= RESET_PC;
            buf_adel_q <= 1'b0;
            cancel_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            addr_q     <= addr_d;
            buf_q      <= buf_d;
            buf_pc_q   <= buf_pc_d;
            buf_adel_q <= buf_adel_d;
            cancel_q   <= cancel_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        addr_d     = addr_q;
        buf_d      = buf_q;
        buf_pc_d   = buf_pc_q;
        buf_adel_d = buf_adel_q;
        cancel_d   = cancel_q;
        unique case (state_q)
            F_REQ: begin
                if (misal) begin
                    if (flushF) begin
                        pc_d   = newpc;
                        addr_d = newpc;
                    end else begin
                        buf_d      = 32'h0;
                        buf_pc_d   = addr_q;
                        buf_adel_d = 1'b1;
                        state_d    = F_FULL;
                    end
                end else begin
                    // addr_q must stay put while req is high, so a flush
                    // here only marks the in-flight word for discard.
                    if (flushF) begin
                        pc_d     = newpc;
                        cancel_d = 1'b1;
                    end
                    if (inst_addr_ok) state_d = F_WAIT;
                end
            end
            F_WAIT: begin
                if (flushF) begin
                    pc_d = newpc;
                    if (inst_data_ok) begin
                        cancel_d = 1'b0;
                        addr_d   = newpc;
                        state_d  = F_REQ;
                    end else begin
                        cancel_d = 1'b1;
                    end
                end else if (inst_data_ok) begin
                    if (cancel_q) begin
                        cancel_d = 1'b0;
                        addr_d   = pc_q;
                        state_d  = F_REQ;
                    end else begin
                        buf_d      = inst_rdata;
                        buf_pc_d   = addr_q;
                        buf_adel_d = 1'b0;
                        state_d    = F_FULL;
                    end
                end
            end
            F_FULL: begin
                if (flushF) begin
                    pc_d    = newpc;
                    addr_d  = newpc;
                    state_d = F_REQ;
                end else if (consume) begin
                    pc_d    = next_pc;
                    addr_d  = next_pc;
                    state_d = F_REQ;
                end
            end
            default: state_d = F_REQ;
        endcase
    end

    always_comb begin
        inst_req = 1'b0;
        validF   = 1'b0;
        unique case (state_q)
            F_REQ:   inst_req = ~misal & ~rst;
            F_FULL:  validF   = 1'b1;
            default: ;
        endcase
    end

    assign inst_addr  = addr_q;
    assign inst_wr    = 1'b0;
    assign inst_size  = SIZE_WORD;
    assign inst_wdata = 32'h0;
    assign instrF     = buf_q;
    assign pcF        = buf_pc_q;
    assign adelF      = buf_adel_q;
    assign i_stall    = ~validF;

endmodule

// File: tb/tb_inst_fetch_sram.sv
// Bench for inst_fetch_sram: table of fetch transactions plus
// hand-written flush, misalignment and reset sequences.
module tb_inst_fetch_sram;

    logic        clk;
    logic        rst;
    logic        stallF;
    logic        flushF;
    logic [31:0] newpc;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        inst_req;
    logic        inst_wr;
    logic [1:0]  inst_size;
    logic [31:0] inst_addr;
    logic [31:0] inst_wdata;
    logic        inst_addr_ok;
    logic        inst_data_ok;
    logic [31:0] inst_rdata;
    logic [31:0] instrF;
    logic [31:0] pcF;
    logic        validF;
    logic        adelF;
    logic        i_stall;

    inst_fetch_sram dut (
        .clk           (clk),
        .rst           (rst),
        .stallF        (stallF),
        .flushF        (flushF),
        .newpc         (newpc),
        .redirect_valid(redirect_valid),
        .redirect_pc   (redirect_pc),
        .inst_req      (inst_req),
        .inst_wr       (inst_wr),
        .inst_size     (inst_size),
        .inst_addr     (inst_addr),
        .inst_wdata    (inst_wdata),
        .inst_addr_ok  (inst_addr_ok),
        .inst_data_ok  (inst_data_ok),
        .inst_rdata    (inst_rdata),
        .instrF        (instrF),
        .pcF           (pcF),
        .validF        (validF),
        .adelF         (adelF),
        .i_stall       (i_stall)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] instr;
        logic [31:0] pc;
        logic        adel;
    } exp_t;

    typedef struct {
        int          addr_dly;
        int          data_dly;
        logic [31:0] rdata;
        int          stall;
        logic        redir;
        logic [31:0] rpc;
        logic [31:0] exp_next;
    } vec_t;

    exp_t        sb[$];
    int          n_chk;
    int          n_pass;
    logic [31:0] cur;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    task automatic check_out();
        exp_t e;
        if (sb.size() == 0) begin
            n_chk++;
            $display("FAIL sb_empty: got validF=%0b expected no output", validF);
        end else begin
            e = sb.pop_front();
            chk("validF", {31'h0, validF}, 32'h1);
            chk("instrF", instrF, e.instr);
            chk("pcF", pcF, e.pc);
            chk("adelF", {31'h0, adelF}, {31'h0, e.adel});
        end
    endtask

    task automatic wait_req(input logic [31:0] addr);
        int n;
        n = 0;
        while (!inst_req && n < 8) begin
            @(negedge clk);
            n++;
        end
        chk("req", {31'h0, inst_req}, 32'h1);
        chk("req_addr", inst_addr, addr);
    endtask

    task automatic fetch_one(input vec_t v);
        logic [31:0] held;
        wait_req(cur);
        for (int i = 0; i < v.addr_dly; i++) begin
            @(negedge clk);
            chk("addr_stable", inst_addr, cur);
        end
        inst_addr_ok = 1'b1;
        sb.push_back('{instr: v.rdata, pc: cur, adel: 1'b0});
        @(negedge clk);
        inst_addr_ok = 1'b0;
        for (int i = 0; i < v.data_dly; i++) begin
            @(negedge clk);
            chk("wait_valid", {31'h0, validF}, 32'h0);
        end
        inst_data_ok = 1'b1;
        inst_rdata   = v.rdata;
        @(negedge clk);
        inst_data_ok = 1'b0;
        inst_rdata   = 32'h0;
        check_out();
        held = instrF;
        for (int i = 0; i < v.stall; i++) begin
            stallF = 1'b1;
            @(negedge clk);
            chk("stall_valid", {31'h0, validF}, 32'h1);
            chk("stall_instr", instrF, held);
            chk("stall_req", {31'h0, inst_req}, 32'h0);
        end
        stallF         = 1'b0;
        redirect_valid = v.redir;
        redirect_pc    = v.rpc;
        @(negedge clk);
        redirect_valid = 1'b0;
        redirect_pc    = 32'h0;
        cur = v.exp_next;
    endtask

    vec_t tbl[6];
    vec_t v;

    initial begin
        n_chk = 0;
        n_pass = 0;
        rst = 1'b1;
        stallF = 1'b0;
        flushF = 1'b0;
        newpc = 32'h0;
        redirect_valid = 1'b0;
        redirect_pc = 32'h0;
        inst_addr_ok = 1'b0;
        inst_data_ok = 1'b0;
        inst_rdata = 32'h0;

        tbl[0] = '{0, 0, 32'h2408_0001, 0, 1'b0, 32'h0,         32'hBFC0_0004};
        tbl[1] = '{1, 2, 32'h8C09_0004, 3, 1'b0, 32'h0,         32'hBFC0_0008};
        tbl[2] = '{0, 0, 32'h1000_0003, 0, 1'b1, 32'hBFC0_0100, 32'hBFC0_0100};
        tbl[3] = '{2, 0, 32'h0000_0000, 1, 1'b1, 32'hFFFF_FFFC, 32'hFFFF_FFFC};
        tbl[4] = '{0, 1, 32'hAABB_CCDD, 0, 1'b0, 32'h0,         32'h0000_0000};
        tbl[5] = '{0, 0, 32'h1234_5678, 0, 1'b1, 32'hBFC0_0200, 32'hBFC0_0200};

        @(negedge clk);
        @(negedge clk);
        chk("rst_req", {31'h0, inst_req}, 32'h0);
        chk("rst_valid", {31'h0, validF}, 32'h0);
        chk("rst_istall", {31'h0, i_stall}, 32'h1);
        chk("rst_instr", instrF, 32'h0);
        chk("rst_pc", pcF, 32'hBFC0_0000);
        chk("rst_adel", {31'h0, adelF}, 32'h0);
        chk("const_wr", {31'h0, inst_wr}, 32'h0);
        chk("const_size", {30'h0, inst_size}, 32'h2);
        chk("const_wdata", inst_wdata, 32'h0);
        rst = 1'b0;
        @(negedge clk);
        cur = 32'hBFC0_0000;

        for (int i = 0; i < 6; i++) fetch_one(tbl[i]);

        // Misaligned redirect target: no bus request, adel buffered.
        v = '{0, 0, 32'h0340_0008, 0, 1'b1, 32'hBFC0_0102, 32'hBFC0_0102};
        fetch_one(v);
        chk("misal_req", {31'h0, inst_req}, 32'h0);
        sb.push_back('{instr: 32'h0, pc: 32'hBFC0_0102, adel: 1'b1});
        @(negedge clk);
        chk("misal_req2", {31'h0, inst_req}, 32'h0);
        check_out();
        redirect_valid = 1'b1;
        redirect_pc    = 32'hBFC0_0300;
        @(negedge clk);
        redirect_valid = 1'b0;
        cur = 32'hBFC0_0300;

        // Flush while REQ pending, addr_ok delayed two cycles.
        wait_req(cur);
        flushF = 1'b1;
        newpc  = 32'hBFC0_0380;
        @(negedge clk);
        flushF = 1'b0;
        chk("fl_req_hold", inst_addr, 32'hBFC0_0300);
        chk("fl_req_on", {31'h0, inst_req}, 32'h1);
        @(negedge clk);
        chk("fl_req_hold2", inst_addr, 32'hBFC0_0300);
        inst_addr_ok = 1'b1;
        @(negedge clk);
        inst_addr_ok = 1'b0;
        inst_data_ok = 1'b1;
        inst_rdata   = 32'hDEAD_BEEF;
        @(negedge clk);
        inst_data_ok = 1'b0;
        chk("fl_drop_valid", {31'h0, validF}, 32'h0);
        chk("fl_new_req", {31'h0, inst_req}, 32'h1);
        chk("fl_new_addr", inst_addr, 32'hBFC0_0380);
        cur = 32'hBFC0_0380;
        v = '{0, 0, 32'h2402_0007, 0, 1'b0, 32'h0, 32'hBFC0_0384};
        fetch_one(v);

        // Flush coincident with data_ok in WAIT.
        wait_req(cur);
        inst_addr_ok = 1'b1;
        @(negedge clk);
        inst_addr_ok = 1'b0;
        inst_data_ok = 1'b1;
        inst_rdata   = 32'hBAD0_BAD0;
        flushF       = 1'b1;
        newpc        = 32'h8000_0180;
        @(negedge clk);
        inst_data_ok = 1'b0;
        flushF       = 1'b0;
        chk("fd_valid", {31'h0, validF}, 32'h0);
        chk("fd_req", {31'h0, inst_req}, 32'h1);
        chk("fd_addr", inst_addr, 32'h8000_0180);
        cur = 32'h8000_0180;
        v = '{1, 0, 32'h0000_000C, 0, 1'b0, 32'h0, 32'h8000_0184};
        fetch_one(v);

        // Reset in the middle of a transaction.
        wait_req(cur);
        inst_addr_ok = 1'b1;
        @(negedge clk);
        inst_addr_ok = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        chk("mrst_req", {31'h0, inst_req}, 32'h0);
        chk("mrst_valid", {31'h0, validF}, 32'h0);
        chk("mrst_pc", pcF, 32'hBFC0_0000);
        rst = 1'b0;
        @(negedge clk);
        cur = 32'hBFC0_0000;
        wait_req(cur);

        n_chk++;
        if (sb.size() == 0) n_pass++;
        else $display("FAIL sb_left: got %0d entries expected 0", sb.size());

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/inst_fetch_sram.md
# inst_fetch_sram

Fetch-stage front end of the MIPS pipeline: owns the fetch PC, issues instruction reads on the sram-like instruction bus, and buffers the returned word until the pipeline consumes it. It sits directly upstream of the hazard unit and the D-stage register:
- consumes `stallF`, `flushF` and the D-stage redirect;
- produces `i_stall`, which the hazard unit ORs into its stall chain.

Exception flushes that arrive while a bus transaction is in flight are absorbed by a cancel mechanism, so stale instructions never reach decode.

## Interface
- `RESET_PC`, default 32'hBFC0_0000: fetch address after reset.
- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `stallF`  in  1  hold the F stage; the buffered instruction is not consumed.
- `flushF`  in  1  exception flush; next fetch is from `newpc`.
- `newpc`  in  32  exception/eret target, valid with `flushF`.
- `redirect_valid`  in  1  branch/jump taken in D.
- `redirect_pc`  in  32  target for `redirect_valid`.
- `inst_req`  out  1  sram-like request.
- `inst_wr`  out  1  constant 0.
- `inst_size`  out  2  constant 2'b10 (word).
- `inst_addr`  out  32  request address.
- `inst_wdata`  out  32  constant 0.
- `inst_addr_ok`  in  1  address accepted.
- `inst_data_ok`  in  1  read data valid.
- `inst_rdata`  in  32  read data.
- `instrF`  out  32  buffered instruction.
- `pcF`  out  32  PC of `instrF`.
- `validF`  out  1  `instrF`/`pcF` hold a live instruction.
- `adelF`  out  1  `pcF` misaligned; `instrF` = 0.
- `i_stall`  out  1  fetch not ready; equals `~validF`.

## Operation
- Registers:
  - `pc_q`: next architectural fetch PC.
  - `addr_q`: address of the request on the bus.
  - `buf_q`, `buf_pc_q`, `buf_adel_q`: buffered result.
  - `cancel_q`: flag to discard the next returning word.
  - `state_q`.
- States:
  - **REQ**: `inst_req`=1, `inst_addr`=`addr_q`.
    - `addr_ok` → WAIT.
    - If `addr_q[1:0]`≠0: no request is driven (`inst_req`=0); load buffer with instr 0, adel 1, pc `addr_q`; → FULL.
  - **WAIT**: `inst_req`=0.
    - `data_ok` with `cancel_q`=0 → latch `inst_rdata` into the buffer → FULL.
    - `data_ok` with `cancel_q`=1 → discard, clear `cancel_q`, set `addr_q`←`pc_q` → REQ.
  - **FULL**: `validF`=1.
    - Consume (`~stallF & ~flushF`): `pc_q`/`addr_q` ← (`redirect_valid` ? `redirect_pc` : `buf_pc_q`+4) → REQ.
    - Otherwise hold.
- `flushF`, highest priority in every state:
  - `pc_q`←`newpc`; buffer invalidated.
  - In FULL, or in REQ with a misaligned address: `addr_q`←`newpc` → REQ.
  - In REQ with an aligned address: set `cancel_q`; `addr_q` is held until `addr_ok` (sram-like rule: address is stable while `req` is high). The request completes, is discarded in WAIT, then a new REQ is issued to `pc_q`.
  - In WAIT with `data_ok` the same cycle: the word is discarded and the next state is REQ with `addr_q`←`newpc`.
  - In WAIT without `data_ok`: set `cancel_q`.
- `redirect_valid` is sampled only in the consume cycle. D holds the branch stable while F is stalled, so no pending-redirect register is needed.
- PC arithmetic is 32-bit and wraps modulo 2^32 (32'hFFFF_FFFC+4 = 0).

## Timing
- Reset values:
  - `state_q`=REQ, `pc_q`=`addr_q`=`RESET_PC`.
  - `validF`=0, `instrF`=0, `pcF`=`RESET_PC`, `adelF`=0, `cancel_q`=0.
  - `inst_req`=0 while `rst`=1, so the first request appears in the cycle after reset deasserts.
- `inst_data_ok` is never asserted in the same cycle as its `addr_ok`.
- Best case, T = `addr_ok` cycle:
  - data_ok at T+1;
  - `validF` at T+2;
  - consume at T+2 → `inst_req` at T+3.
  - One instruction every 3 cycles; unbounded bus wait states are allowed.
- Reset mid-transaction: all state returns to reset values. The bus is assumed to be reset with the core, so no cancel is carried over.
- Outputs are registered except `inst_req`/`inst_addr` (decoded from `state_q`/`addr_q`) and `i_stall`.

## Structure
- The shared cpu package holds:
  - the fetch state enum (REQ, WAIT, FULL);
  - `SIZE_WORD` = 2'b10;
  - the reset PC constant `RESET_PC_DEFAULT` = 32'hBFC0_0000.
- The package does not hold the exception vector: `newpc` is computed by the exception unit.
- Single flat module; no sub-module is warranted.

## Test plan
- Reset then `addr_ok`=1 immediately, data_ok next cycle with rdata 32'h2408_0001 → `validF`=1, `pcF`=32'hBFC0_0000, next `inst_addr`=32'hBFC0_0004.
- `stallF` high 3 cycles while FULL → `instrF`/`pcF` unchanged and `inst_req`=0; after release, next request to `pc`+4.
- `redirect_valid`=1, `redirect_pc`=32'hBFC0_0100 in the consume cycle → next `inst_addr`=32'hBFC0_0100.
- `flushF` with `newpc`=32'hBFC0_0380 while REQ is pending and `addr_ok` is delayed 2 cycles:
  - `inst_addr` stays at the old value until `addr_ok`;
  - the returned word is dropped (`validF` stays 0);
  - the next request is to 32'hBFC0_0380.
- `redirect_pc`=32'hBFC0_0102 → no bus request; `validF`=1, `adelF`=1, `instrF`=0, `pcF`=32'hBFC0_0102.
- `flushF` coincident with `data_ok` in WAIT → word discarded; `inst_addr`=`newpc` on the next cycle.
